// File: rtl/mem_port_arbiter.sv
// Shares one synchronous RAM port between instruction fetch and load/store.
// Round-robin arbitration, one registered access cycle, one-cycle ack.
module mem_port_arbiter #(
  parameter int WIDTH     = 16,
  parameter int ADDR_BITS = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 if_req,
  input  logic [ADDR_BITS-1:0] if_addr,
  output logic [WIDTH-1:0]     if_rdata,
  output logic                 if_ack,
  input  logic                 d_req,
  input  logic                 d_we,
  input  logic [ADDR_BITS-1:0] d_addr,
  input  logic [WIDTH-1:0]     d_wdata,
  output logic [WIDTH-1:0]     d_rdata,
  output logic                 d_ack,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic [WIDTH-1:0]     mem_wdata,
  output logic                 mem_we,
  input  logic [WIDTH-1:0]     mem_rdata,
  output logic                 busy,
  output logic                 grant_d
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  state_t state;
  state_t state_nxt;

  logic last_grant;
  logic owner_we;
  logic if_elig;
  logic d_elig;
  logic gnt_if;
  logic gnt_d;

  // A requester whose ack is high is still holding the old request.
  assign if_elig = if_req & ~if_ack;
  assign d_elig  = d_req & ~d_ack;

  assign busy = (state != IDLE);

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and round-robin grant decision.
  always_comb begin
    state_nxt = state;
    gnt_if    = 1'b0;
    gnt_d     = 1'b0;
    unique case (state)
      IDLE: begin
        if (if_elig && d_elig) begin
          if (last_grant) begin
            gnt_if = 1'b1;
          end else begin
            gnt_d = 1'b1;
          end
        end else if (if_elig) begin
          gnt_if = 1'b1;
        end else if (d_elig) begin
          gnt_d = 1'b1;
        end
        if (gnt_if || gnt_d) begin
          state_nxt = ACCESS;
        end
      end
      ACCESS: state_nxt = RESP;
      RESP:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // RAM drive, read-data capture and ack generation.
  always_ff @(posedge clk) begin
    if (!reset) begin
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_we     <= 1'b0;
      if_rdata   <= '0;
      d_rdata    <= '0;
      if_ack     <= 1'b0;
      d_ack      <= 1'b0;
      grant_d    <= 1'b0;
      last_grant <= 1'b1;
      owner_we   <= 1'b0;
    end else begin
      if_ack <= 1'b0;
      d_ack  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (gnt_if) begin
            mem_addr   <= if_addr;
            mem_we     <= 1'b0;
            owner_we   <= 1'b0;
            grant_d    <= 1'b0;
            last_grant <= 1'b0;
          end else if (gnt_d) begin
            mem_addr   <= d_addr;
            owner_we   <= d_we;
            grant_d    <= 1'b1;
            last_grant <= 1'b1;
            if (d_we) begin
              mem_wdata <= d_wdata;
              mem_we    <= 1'b1;
            end
          end
        end
        ACCESS: begin
          mem_we <= 1'b0;
        end
        RESP: begin
          if (grant_d) begin
            if (!owner_we) begin
              d_rdata <= mem_rdata;
            end
            d_ack <= 1'b1;
          end else begin
            if_rdata <= mem_rdata;
            if_ack   <= 1'b1;
          end
        end
        default: begin
          mem_we <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: vector table plus corner-case sequences,
// with an ack-driven scoreboard and a behavioural synchronous RAM.
module tb_mem_port_arbiter;

  localparam int W = 16;
  localparam int A = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic         if_req;
  logic [A-1:0] if_addr;
  logic [W-1:0] if_rdata;
  logic         if_ack;
  logic         d_req;
  logic         d_we;
  logic [A-1:0] d_addr;
  logic [W-1:0] d_wdata;
  logic [W-1:0] d_rdata;
  logic         d_ack;
  logic [A-1:0] mem_addr;
  logic [W-1:0] mem_wdata;
  logic         mem_we;
  logic [W-1:0] mem_rdata;
  logic         busy;
  logic         grant_d;

  logic         bd_en;
  logic [A-1:0] bd_addr;
  logic [W-1:0] bd_data;
  logic [W-1:0] ram [0:65535];

  int total = 0;
  int bad   = 0;
  int n_ack = 0;
  logic p_if = 1'b0;
  logic p_d  = 1'b0;

  typedef struct {
    logic         isd;
    logic [W-1:0] exp_if;
    logic [W-1:0] exp_d;
  } sb_t;
  sb_t sbq[$];

  typedef struct {
    logic         isd;
    logic         we;
    logic [A-1:0] addr;
    logic [W-1:0] wdata;
    logic         pre;
    logic [W-1:0] pval;
    logic         hold;
    logic [W-1:0] exp_if;
    logic [W-1:0] exp_d;
  } vec_t;
  vec_t tbl [8];

  mem_port_arbiter #(.WIDTH(W), .ADDR_BITS(A)) dut (
    .clk(clk),
    .reset(reset),
    .if_req(if_req),
    .if_addr(if_addr),
    .if_rdata(if_rdata),
    .if_ack(if_ack),
    .d_req(d_req),
    .d_we(d_we),
    .d_addr(d_addr),
    .d_wdata(d_wdata),
    .d_rdata(d_rdata),
    .d_ack(d_ack),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_we(mem_we),
    .mem_rdata(mem_rdata),
    .busy(busy),
    .grant_d(grant_d)
  );

  always #5 clk = ~clk;

  // Read-first synchronous RAM with a backdoor write port.
  always @(posedge clk) begin
    mem_rdata <= ram[mem_addr];
    if (mem_we) ram[mem_addr] <= mem_wdata;
    if (bd_en) ram[bd_addr] <= bd_data;
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // One cycle: sample at negedge and retire any ack against the scoreboard.
  task automatic tick();
    sb_t e;
    @(negedge clk);
    if (if_ack && d_ack) chk("ack_both", 1, 0);
    if (if_ack || d_ack) begin
      n_ack++;
      if (sbq.size() == 0) begin
        chk("ack_spurious", {30'd0, if_ack, d_ack}, 0);
      end else begin
        e = sbq.pop_front();
        chk("ack_owner", {31'd0, d_ack}, {31'd0, e.isd});
        chk("grant_d", {31'd0, grant_d}, {31'd0, e.isd});
        chk("if_rdata", {16'd0, if_rdata}, {16'd0, e.exp_if});
        chk("d_rdata", {16'd0, d_rdata}, {16'd0, e.exp_d});
        chk("ack_pulse", {31'd0, (if_ack && p_if) || (d_ack && p_d)}, 0);
      end
    end
    p_if = if_ack;
    p_d  = d_ack;
  endtask

  task automatic preload(input logic [A-1:0] a, input logic [W-1:0] v);
    bd_en   = 1'b1;
    bd_addr = a;
    bd_data = v;
    tick();
    bd_en = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_if_rdata"}, {16'd0, if_rdata}, 0);
    chk({tag, "_d_rdata"}, {16'd0, d_rdata}, 0);
    chk({tag, "_acks"}, {30'd0, if_ack, d_ack}, 0);
    chk({tag, "_mem_addr"}, {16'd0, mem_addr}, 0);
    chk({tag, "_mem_wdata"}, {16'd0, mem_wdata}, 0);
    chk({tag, "_we_busy_gnt"}, {29'd0, mem_we, busy, grant_d}, 0);
  endtask

  task automatic run_one(input vec_t v);
    int n;
    int wes;
    int a0;
    if (v.pre) preload(v.addr, v.pval);
    sbq.push_back('{v.isd, v.exp_if, v.exp_d});
    if (v.isd) begin
      d_req   = 1'b1;
      d_we    = v.we;
      d_addr  = v.addr;
      d_wdata = v.wdata;
    end else begin
      if_req  = 1'b1;
      if_addr = v.addr;
    end
    n   = 0;
    wes = 0;
    a0  = n_ack;
    do begin
      tick();
      n++;
      if (n == 1) chk("busy_access", {31'd0, busy}, 1);
      if (mem_we) begin
        wes++;
        chk("we_addr", {16'd0, mem_addr}, {16'd0, v.addr});
        chk("we_data", {16'd0, mem_wdata}, {16'd0, v.wdata});
      end
    end while (n_ack == a0 && n < 20);
    chk("latency", n, 3);
    chk("we_cycles", wes, (v.isd && v.we) ? 1 : 0);
    if (v.hold) tick();
    if_req = 1'b0;
    d_req  = 1'b0;
    d_we   = 1'b0;
    repeat (4) tick();
    chk("acks_per_req", n_ack - a0, 1);
    chk("sb_empty", sbq.size(), 0);
    chk("idle_busy_we", {30'd0, busy, mem_we}, 0);
    sbq.delete();
  endtask

  task automatic pair(input logic [A-1:0] ia, input logic [A-1:0] da,
                      input bit hold_all, input int nacks);
    int n;
    int a0;
    a0      = n_ack;
    n       = 0;
    if_req  = 1'b1;
    if_addr = ia;
    d_req   = 1'b1;
    d_we    = 1'b0;
    d_addr  = da;
    while (n < 40 && (if_req || d_req)) begin
      tick();
      n++;
      if (hold_all) begin
        if (n_ack - a0 >= nacks) begin
          if_req = 1'b0;
          d_req  = 1'b0;
        end
      end else begin
        if (if_ack) if_req = 1'b0;
        if (d_ack) d_req = 1'b0;
      end
    end
    if_req = 1'b0;
    d_req  = 1'b0;
    repeat (4) tick();
    chk("pair_acks", n_ack - a0, nacks);
    chk("pair_sb", sbq.size(), 0);
    sbq.delete();
  endtask

  initial begin
    int a0;
    tbl[0] = '{1'b0, 1'b0, 16'h0010, 16'h0000, 1'b1, 16'hBEEF, 1'b0,
               16'hBEEF, 16'h0000};
    tbl[1] = '{1'b1, 1'b1, 16'h0020, 16'h1234, 1'b0, 16'h0000, 1'b0,
               16'hBEEF, 16'h0000};
    tbl[2] = '{1'b1, 1'b0, 16'h0020, 16'h0000, 1'b0, 16'h0000, 1'b1,
               16'hBEEF, 16'h1234};
    tbl[3] = '{1'b0, 1'b0, 16'h0001, 16'h0000, 1'b1, 16'h00AA, 1'b1,
               16'h00AA, 16'h1234};
    tbl[4] = '{1'b1, 1'b0, 16'h0002, 16'h0000, 1'b1, 16'h5555, 1'b0,
               16'h00AA, 16'h5555};
    tbl[5] = '{1'b1, 1'b1, 16'h0003, 16'hA5A5, 1'b0, 16'h0000, 1'b0,
               16'h00AA, 16'h5555};
    tbl[6] = '{1'b0, 1'b0, 16'h0003, 16'h0000, 1'b0, 16'h0000, 1'b0,
               16'hA5A5, 16'h5555};
    tbl[7] = '{1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, 16'h0000, 1'b0,
               16'hA5A5, 16'hBEEF};

    reset   = 1'b0;
    if_req  = 1'b0;
    if_addr = '0;
    d_req   = 1'b0;
    d_we    = 1'b0;
    d_addr  = '0;
    d_wdata = '0;
    bd_en   = 1'b0;
    bd_addr = '0;
    bd_data = '0;
    repeat (2) tick();
    chk_zero("rst");
    reset = 1'b1;
    tick();
    chk_zero("post_rst");

    for (int i = 0; i < 8; i++) run_one(tbl[i]);

    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    chk_zero("rst2");

    sbq.push_back('{1'b0, 16'hBEEF, 16'h0000});
    sbq.push_back('{1'b1, 16'hBEEF, 16'hBEEF});
    sbq.push_back('{1'b0, 16'hBEEF, 16'hBEEF});
    pair(16'h0010, 16'h0010, 1'b1, 3);

    sbq.push_back('{1'b1, 16'hBEEF, 16'h5555});
    sbq.push_back('{1'b0, 16'h00AA, 16'h5555});
    pair(16'h0001, 16'h0002, 1'b0, 2);

    a0      = n_ack;
    d_req   = 1'b1;
    d_we    = 1'b1;
    d_addr  = 16'h0030;
    d_wdata = 16'h7777;
    tick();
    chk("mid_we", {30'd0, mem_we, busy}, 3);
    reset = 1'b0;
    tick();
    d_req = 1'b0;
    d_we  = 1'b0;
    chk_zero("mid_rst");
    tick();
    reset = 1'b1;
    repeat (4) tick();
    chk_zero("mid_after");
    chk("mid_no_ack", n_ack - a0, 0);

    run_one('{1'b0, 1'b0, 16'h0001, 16'h0000, 1'b0, 16'h0000, 1'b0,
              16'h00AA, 16'h0000});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port synchronous data/instruction RAM between two requesters: the instruction-fetch path and the load/store path driven by the controller's LOAD/STOR phases.
- Registers the winning request, drives the RAM for one access cycle, captures read data and returns a one-cycle ack to the owner.
- Round-robin on simultaneous requests, so neither fetch nor data starves.

Parameters:
WIDTH, 16, data word width
ADDR_BITS, 16, RAM address width

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-low reset
if_req  input  1  fetch read request, level, held until if_ack sampled
if_addr  input  ADDR_BITS  fetch address
if_rdata  output  WIDTH  fetched word, valid with if_ack, held until next fetch completes
if_ack  output  1  one-cycle fetch completion pulse
d_req  input  1  data request, level, held until d_ack sampled
d_we  input  1  1 = store, 0 = load
d_addr  input  ADDR_BITS  data address
d_wdata  input  WIDTH  store data
d_rdata  output  WIDTH  load data, valid with d_ack, held until next load completes
d_ack  output  1  one-cycle data completion pulse
mem_addr  output  ADDR_BITS  RAM address (registered)
mem_wdata  output  WIDTH  RAM write data (registered)
mem_we  output  1  RAM write enable (registered)
mem_rdata  input  WIDTH  RAM read data, valid the cycle after address is captured
busy  output  1  high whenever state != IDLE
grant_d  output  1  current/last owner: 1 = data, 0 = fetch

Behaviour:
- Reset is synchronous: reset low at an edge forces state IDLE. All outputs go to 0: if_rdata, d_rdata, if_ack, d_ack, mem_addr, mem_wdata, mem_we, busy, grant_d. last_grant is set to data, so fetch wins the first tie.
- Reset mid-transaction aborts the transaction: no ack is issued, and mem_we is 0 from the next cycle.
- FSM states: IDLE, ACCESS, RESP.
- IDLE, arbitration:
  - Eligible requester: req=1 and its own ack is not high this cycle. An ack-high requester is masked so a request still held during its ack cycle is not re-served.
  - Only one eligible: grant it.
  - Both eligible: grant the one that is not last_grant.
  - On grant, at the edge: register mem_addr from the winner's address. For a data store, also register mem_wdata=d_wdata and mem_we=1. Update grant_d and last_grant. Go to ACCESS.
- ACCESS (exactly 1 cycle): RAM captures address/write at the closing edge. mem_we is cleared at that edge; go to RESP.
- RESP (exactly 1 cycle): mem_rdata is valid. At the closing edge:
  - Read: latch mem_rdata into the owner's rdata register.
  - Store: owner's rdata is unchanged.
  - Set the owner's ack=1 for the next cycle and go to IDLE.
- Ack is high for exactly one cycle, then cleared.
- Latency: request sampled at edge E0 -> ack high in the cycle after E2 (3 cycles).
- Throughput: with continuous requests, a new grant can occur at E3, i.e. one access per 3 cycles.
- Requesters must hold req/addr/we/wdata stable until they sample ack. Input changes after the grant edge are ignored, because mem_* are registered at grant.
- The unused rdata register is never modified by the other requester's transaction.
- mem_addr and mem_wdata hold their last values in IDLE; only mem_we returns to 0.
- busy=1 in ACCESS and RESP.

Test Plan:
- Fetch only: write 0xBEEF at RAM[0x0010] via backdoor; if_req=1, if_addr=0x0010 -> if_ack high for one cycle, 3 cycles after the request edge; if_rdata=0xBEEF; d_ack stays 0; mem_we never 1.
- Store then load: d_req, d_we=1, d_addr=0x0020, d_wdata=0x1234 -> mem_we high for exactly one cycle with mem_addr=0x0020; d_ack pulses; d_rdata unchanged. Then load 0x0020 -> d_rdata=0x1234.
- Simultaneous requests after reset: if_req and d_req both held -> fetch granted first (grant_d=0); data granted at the next IDLE. Grants alternate fetch, data, fetch while both are held, and each ack is a single pulse.
- No double service: requester keeps req high during its ack cycle, deasserts one cycle later -> exactly one ack for that request.
- Reset mid-op: assert reset low during ACCESS of a store -> next cycle state IDLE, mem_we=0, no d_ack, busy=0, all outputs 0. The first fetch after release completes normally.
- Data isolation: fetch RAM[0x0001]=0x00AA, then load RAM[0x0002]=0x5555 -> if_rdata stays 0x00AA after the load; d_rdata=0x5555.
